// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: captures the instruction leaving EX, honours stall/flush,
// turns trapping signed overflows into bubbles with an exception pulse, and freezes on halt.
module ex_mem_latch #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          en,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_result,
  input  logic          in_zero,
  input  logic          in_overflow,
  input  logic          in_ovf_en,
  input  logic [DW-1:0] in_stdata,
  input  logic [RW-1:0] in_wsel,
  input  logic          in_regwen,
  input  logic          in_dren,
  input  logic          in_dwen,
  input  logic          in_halt,
  input  logic [DW-1:0] in_pc,
  output logic          out_valid,
  output logic          out_zero,
  output logic          out_regwen,
  output logic          out_dren,
  output logic          out_dwen,
  output logic          out_halt,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_stdata,
  output logic [DW-1:0] out_pc,
  output logic [RW-1:0] out_wsel,
  output logic          exc_ovf,
  output logic [DW-1:0] epc,
  output logic          halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          zero;
    logic          regwen;
    logic          dren;
    logic          dwen;
    logic          halt;
    logic [DW-1:0] result;
    logic [DW-1:0] stdata;
    logic [DW-1:0] pc;
    logic [RW-1:0] wsel;
  } latch_t;

  state_t          state_q, state_d;
  latch_t          lat_q, lat_d;
  latch_t          in_lat;
  logic            exc_q, exc_d;
  logic [DW-1:0]   epc_q, epc_d;
  logic            trap;

  // Control bits are qualified by in_valid so an invalid slot can never write anything.
  always_comb begin
    in_lat        = '0;
    in_lat.valid  = in_valid;
    in_lat.zero   = in_zero;
    in_lat.regwen = in_regwen & in_valid;
    in_lat.dren   = in_dren & in_valid;
    in_lat.dwen   = in_dwen & in_valid;
    in_lat.halt   = in_halt & in_valid;
    in_lat.result = in_result;
    in_lat.stdata = in_stdata;
    in_lat.pc     = in_pc;
    in_lat.wsel   = in_wsel;
  end

  assign trap = in_valid & in_ovf_en & in_overflow;

  // Priority in RUN: flush, then stall, then trap, then normal capture.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    exc_d   = 1'b0;
    epc_d   = epc_q;
    case (state_q)
      RUN: begin
        if (flush) begin
          lat_d = '0;
        end else if (en) begin
          if (trap) begin
            lat_d = '0;
            exc_d = 1'b1;
            epc_d = in_pc;
          end else begin
            lat_d = in_lat;
            if (in_valid && in_halt) begin
              state_d = HALTED;
            end
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      lat_q   <= '0;
      exc_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  assign out_valid  = lat_q.valid;
  assign out_zero   = lat_q.zero;
  assign out_regwen = lat_q.regwen;
  assign out_dren   = lat_q.dren;
  assign out_dwen   = lat_q.dwen;
  assign out_halt   = lat_q.halt;
  assign out_result = lat_q.result;
  assign out_stdata = lat_q.stdata;
  assign out_pc     = lat_q.pc;
  assign out_wsel   = lat_q.wsel;
  assign exc_ovf    = exc_q;
  assign epc        = epc_q;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized and directed bench for ex_mem_latch against a rule-level reference model.
module tb_ex_mem_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, in_valid, in_zero, in_overflow, in_ovf_en;
  logic [31:0] in_result, in_stdata, in_pc;
  logic [4:0]  in_wsel;
  logic        in_regwen, in_dren, in_dwen, in_halt;
  logic        out_valid, out_zero, out_regwen, out_dren, out_dwen, out_halt;
  logic [31:0] out_result, out_stdata, out_pc;
  logic [4:0]  out_wsel;
  logic        exc_ovf, halted;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ex_mem_latch #(.DW(32), .RW(5)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .in_valid(in_valid),
    .in_result(in_result), .in_zero(in_zero), .in_overflow(in_overflow),
    .in_ovf_en(in_ovf_en), .in_stdata(in_stdata), .in_wsel(in_wsel),
    .in_regwen(in_regwen), .in_dren(in_dren), .in_dwen(in_dwen),
    .in_halt(in_halt), .in_pc(in_pc),
    .out_valid(out_valid), .out_zero(out_zero), .out_regwen(out_regwen),
    .out_dren(out_dren), .out_dwen(out_dwen), .out_halt(out_halt),
    .out_result(out_result), .out_stdata(out_stdata), .out_pc(out_pc),
    .out_wsel(out_wsel), .exc_ovf(exc_ovf), .epc(epc), .halted(halted)
  );

  // Expected architectural view of the latch.
  typedef struct {
    logic        valid, zero, regwen, dren, dwen, halt;
    logic [31:0] result, stdata, pc;
    logic [4:0]  wsel;
    logic        exc;
    logic [31:0] epc;
    logic        halted;
  } exp_t;

  exp_t m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{default: '0};
  endfunction

  function automatic void model_bubble();
    m.valid = 0; m.zero = 0; m.regwen = 0; m.dren = 0; m.dwen = 0; m.halt = 0;
    m.result = 0; m.stdata = 0; m.pc = 0; m.wsel = 0;
  endfunction

  // One rising edge, applied to the inputs present just before it.
  function automatic void model_edge();
    if (m.halted) begin
      m.exc = 0;
    end else if (flush) begin
      model_bubble();
      m.exc = 0;
    end else if (!en) begin
      m.exc = 0;
    end else if (in_valid && in_ovf_en && in_overflow) begin
      model_bubble();
      m.exc = 1;
      m.epc = in_pc;
    end else begin
      m.valid  = in_valid;
      m.zero   = in_zero;
      m.regwen = in_valid && in_regwen;
      m.dren   = in_valid && in_dren;
      m.dwen   = in_valid && in_dwen;
      m.halt   = in_valid && in_halt;
      m.result = in_result;
      m.stdata = in_stdata;
      m.pc     = in_pc;
      m.wsel   = in_wsel;
      m.exc    = 0;
      if (in_valid && in_halt) m.halted = 1;
    end
  endfunction

  task automatic compare_all();
    check_eq("valid",  out_valid,  m.valid);
    check_eq("zero",   out_zero,   m.zero);
    check_eq("regwen", out_regwen, m.regwen);
    check_eq("dren",   out_dren,   m.dren);
    check_eq("dwen",   out_dwen,   m.dwen);
    check_eq("halt",   out_halt,   m.halt);
    check_eq("result", out_result, m.result);
    check_eq("stdata", out_stdata, m.stdata);
    check_eq("pc",     out_pc,     m.pc);
    check_eq("wsel",   out_wsel,   m.wsel);
    check_eq("exc",    exc_ovf,    m.exc);
    check_eq("epc",    epc,        m.epc);
    check_eq("halted", halted,     m.halted);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (nRST) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    en = 1; flush = 0; in_valid = 0; in_zero = 0; in_overflow = 0; in_ovf_en = 0;
    in_result = 0; in_stdata = 0; in_pc = 0; in_wsel = 0;
    in_regwen = 0; in_dren = 0; in_dwen = 0; in_halt = 0;
  endtask

  task automatic rand_inputs(input int halt_pct);
    en          = ($urandom_range(99) < 80);
    flush       = ($urandom_range(99) < 10);
    in_valid    = ($urandom_range(99) < 75);
    in_zero     = $urandom_range(1);
    in_overflow = $urandom_range(1);
    in_ovf_en   = $urandom_range(1);
    in_result   = $urandom;
    in_stdata   = $urandom;
    in_pc       = $urandom & 32'hFFFF_FFFC;
    in_wsel     = 5'($urandom);
    in_regwen   = $urandom_range(1);
    in_dren     = $urandom_range(1);
    in_dwen     = $urandom_range(1);
    in_halt     = ($urandom_range(99) < halt_pct);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    nRST = 1;
  endtask

  int halt_cycles;

  initial begin
    // Reset with arbitrary inputs applied
    nRST = 0;
    rand_inputs(50);
    #12;
    model_reset();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_epc", epc, 0);
    compare_all();
    idle_inputs();
    in_valid = 1; in_result = 32'h0000_00FF; in_wsel = 5; in_regwen = 1;
    @(negedge CLK);
    nRST = 1;
    tick();
    check_eq("first_result", out_result, 32'hFF);
    check_eq("first_wsel", out_wsel, 5);
    check_eq("first_regwen", out_regwen, 1);
    check_eq("first_valid", out_valid, 1);

    // Stall then flush
    idle_inputs();
    in_valid = 1; in_result = 32'h1234_5678; in_regwen = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(0);
      en = 0; flush = 0;
      tick();
      check_eq("stall_result", out_result, 32'h1234_5678);
    end
    en = 0; flush = 1;
    tick();
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_regwen", out_regwen, 0);
    check_eq("flush_result", out_result, 0);

    // Overflow trap, then ordinary edge, then non-trapping overflow
    idle_inputs();
    in_valid = 1; in_result = 32'h8000_0000; in_overflow = 1; in_ovf_en = 1;
    in_pc = 32'h40; in_regwen = 1;
    tick();
    check_eq("trap_valid", out_valid, 0);
    check_eq("trap_regwen", out_regwen, 0);
    check_eq("trap_exc", exc_ovf, 1);
    check_eq("trap_epc", epc, 32'h40);
    in_ovf_en = 0; in_pc = 32'h44;
    tick();
    check_eq("post_exc", exc_ovf, 0);
    check_eq("post_epc", epc, 32'h40);
    check_eq("nontrap_result", out_result, 32'h8000_0000);
    check_eq("nontrap_valid", out_valid, 1);

    // Back-to-back traps
    in_ovf_en = 1; in_pc = 32'h100;
    tick();
    check_eq("b2b_exc0", exc_ovf, 1);
    in_pc = 32'h104;
    tick();
    check_eq("b2b_exc1", exc_ovf, 1);
    check_eq("b2b_epc1", epc, 32'h104);

    // Priority collisions
    flush = 1; in_pc = 32'h200;
    tick();
    check_eq("flushtrap_exc", exc_ovf, 0);
    check_eq("flushtrap_valid", out_valid, 0);
    idle_inputs();
    flush = 1; in_valid = 1; in_halt = 1;
    tick();
    check_eq("flushhalt_halted", halted, 0);
    idle_inputs();
    in_valid = 0; in_dwen = 1;
    tick();
    check_eq("inv_dwen", out_dwen, 0);

    // Halt freeze and reset exit
    idle_inputs();
    in_valid = 1; in_halt = 1; in_result = 32'hCAFE_0001;
    tick();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_out", out_halt, 1);
    for (int i = 0; i < 3; i++) begin
      rand_inputs(50);
      flush = (i == 0);
      tick();
      check_eq("frozen_result", out_result, 32'hCAFE_0001);
    end
    pulse_reset();
    check_eq("unhalt", halted, 0);
    check_eq("unhalt_result", out_result, 0);

    // Randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(3);
      tick();
      halt_cycles = m.halted ? halt_cycles + 1 : 0;
      if (halt_cycles > 4 || $urandom_range(199) == 0) begin
        pulse_reset();
        halt_cycles = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

Pipeline register between the execute stage and the memory stage of the five-stage core. It captures the ALU result, flags and control bundle for the instruction leaving EX. It honours stall (hold) and flush (bubble) requests from the hazard unit, and converts signed-overflow instructions into bubbles while raising a one-cycle overflow exception with the faulting PC. It also freezes the pipeline tail once a halt instruction has been latched.

## Interface
- Parameters:
  - DW, 32, datapath width.
  - RW, 5, register-select width.
- Ports:
  - CLK  in  1  core clock; all state updates on rising edge.
  - nRST  in  1  asynchronous, active-low reset.
  - en  in  1  advance enable; 0 = hold current contents (stall).
  - flush  in  1  1 = load a bubble instead of the EX instruction.
  - in_valid  in  1  EX holds a real instruction.
  - in_result  in  DW  ALU port_out.
  - in_zero, in_overflow  in  1 each  ALU flags.
  - in_ovf_en  in  1  instruction is a trapping signed op (ADD/SUB, ADDI).
  - in_stdata  in  DW  store data (forwarded rt value).
  - in_wsel  in  RW  destination register.
  - in_regwen, in_dren, in_dwen, in_halt  in  1 each  control bits.
  - in_pc  in  DW  PC of the EX instruction.
  - out_valid, out_zero, out_regwen, out_dren, out_dwen, out_halt  out  1 each  latched fields.
  - out_result, out_stdata, out_pc  out  DW  latched fields.
  - out_wsel  out  RW  latched destination.
  - exc_ovf  out  1  overflow-exception pulse.
  - epc  out  DW  PC of the most recent trapped instruction.
  - halted  out  1  latch frozen on halt.

## Operation
- Reset: every output is 0, and the state is RUN.
- State RUN. On each edge, the first matching rule applies:
  - flush=1: load a bubble. All valid and control outputs go to 0; data fields also go to 0. No trap is taken.
  - en=0: all fields hold their values.
  - Trap: en=1, in_valid=1, in_ovf_en=1 and in_overflow=1.
    - Load a bubble.
    - Set exc_ovf=1 and epc=in_pc.
    - in_halt is ignored.
  - Otherwise (en=1): load all in_* fields.
    - out_* control bits are ANDed with in_valid, so an invalid input never writes.
    - If in_valid=1 and in_halt=1, go to HALTED.
- State HALTED:
  - All out_* fields and epc hold.
  - en and flush are ignored; halted=1.
  - Only nRST leaves this state.
- exc_ovf is registered and lasts exactly one cycle.
  - It is cleared on any edge that does not itself take a trap, including stall and flush edges.
  - epc is sticky until the next trap or reset.
- Non-trapping overflow (in_ovf_en=0, e.g. ADDU/SUBU) latches normally, with out_result holding the wrapped value.
- No arithmetic is performed; all fields are full-width copies.

## Timing
- Latency: 1 cycle. in_* fields sampled at edge N appear on out_* after edge N.
- All outputs are purely registered, with no combinational path from input to output.
- nRST assertion mid-operation clears all outputs immediately (asynchronous) and leaves HALTED. The latch resumes capturing on the first edge after deassertion.
- Back-to-back traps give exc_ovf high for consecutive cycles, with epc updated on each.
- A halt and a flush on the same edge: flush wins, and the latch stays in RUN.
- halted rises on the same edge that latches out_halt=1.

## Test plan
- Reset: hold nRST=0 and drive arbitrary inputs -> all outputs read 0. Release nRST with en=1, in_valid=1, in_result=0x0000_00FF, in_wsel=5, in_regwen=1 -> after the next edge: out_result=0xFF, out_wsel=5, out_regwen=1, out_valid=1.
- Stall then flush: latch 0x1234_5678. Drop en for 3 edges while changing inputs -> out_result stays 0x1234_5678. Then flush=1 with en=0 -> out_valid=0, out_regwen=0, out_result=0.
- Overflow trap: in_result=0x8000_0000, in_overflow=1, in_ovf_en=1, in_pc=0x0000_0040, in_regwen=1 -> after one edge: out_valid=0, out_regwen=0, exc_ovf=1, epc=0x40. After the next ordinary edge: exc_ovf=0 and epc still 0x40. Repeat with in_ovf_en=0 -> the result latches normally and exc_ovf stays 0.
- Halt freeze: latch in_halt=1, in_valid=1 -> halted=1 and out_halt=1. Then flush=1 and new inputs -> outputs unchanged. Pulse nRST -> all outputs 0 and halted=0.
- Priority collisions:
  - flush=1 with a trapping overflow -> bubble, exc_ovf=0.
  - flush=1 with in_valid=1, in_halt=1 -> halted=0.
  - en=1, in_valid=0, in_dwen=1 -> out_dwen=0.
